// File: rtl/seq_alu.sv
// Sequential ALU with a start/busy/done handshake, registered result and flags,
// variable shifts and a WIDTH-step signed shift-add multiplier.
`timescale 1ns/1ps
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic [2:0]       d
);

  localparam int CW = SHW + 1;
  localparam logic [2*WIDTH-1:0] HALF = (2*WIDTH)'(1) << (WIDTH-1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t                  state, state_next;
  logic                    accept, step, finish;
  logic [2:0]              op;
  logic signed [WIDTH-1:0] opa, opb;
  logic [2*WIDTH-1:0]      acc, mcand;
  logic [WIDTH-1:0]        mplier;
  logic [CW-1:0]           cnt;
  logic                    msign;

  logic signed [WIDTH-1:0] sum, diff, res;
  logic [SHW-1:0]          sh;
  logic                    mul_neg, ovf;
  logic [2*WIDTH-1:0]      prod;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  // Left shift is unrepresentable when shifting back arithmetically loses bits.
  function automatic logic sla_ovf(input logic signed [WIDTH-1:0] x, input logic [SHW-1:0] s);
    logic signed [WIDTH-1:0] t;
    t = x <<< s;
    return (t >>> s) != x;
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sc);
    return (sa == sb) && (sc != sa);
  endfunction

  function automatic logic mul_ovf(input logic [2*WIDTH-1:0] p, input logic neg);
    return neg ? (p > HALF) : (p >= HALF);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = (opcode == 3'b100) ? MUL : EXEC;
      end
      EXEC: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      MUL: if (cnt == CW'(WIDTH)) begin
        finish     = 1'b1;
        state_next = IDLE;
      end else begin
        step = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sh      = opb[SHW-1:0];
  assign sum     = opa + opb;
  assign diff    = opa - opb;
  assign mul_neg = msign && (acc != '0);
  assign prod    = mul_neg ? -acc : acc;

  always_comb begin
    res = ~opa;
    ovf = 1'b0;
    case (op)
      3'b000: begin res = opa <<< sh; ovf = sla_ovf(opa, sh); end
      3'b001: res = opa >>> sh;
      3'b010: begin res = sum;  ovf = add_ovf(opa[WIDTH-1], opb[WIDTH-1], sum[WIDTH-1]); end
      3'b011: begin res = diff; ovf = add_ovf(opa[WIDTH-1], ~opb[WIDTH-1], diff[WIDTH-1]); end
      3'b100: begin res = prod[WIDTH-1:0]; ovf = mul_ovf(acc, mul_neg); end
      3'b101: res = opa & opb;
      3'b110: res = opa | opb;
      default: res = ~opa;
    endcase
  end

  // Operand latch, multiplier step and result writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      msign  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      c      <= '0;
      d      <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        op     <= opcode;
        opa    <= a;
        opb    <= b;
        acc    <= '0;
        cnt    <= '0;
        msign  <= a[WIDTH-1] ^ b[WIDTH-1];
        mcand  <= {{WIDTH{1'b0}}, mag(a)};
        mplier <= mag(b);
        busy   <= 1'b1;
      end
      if (step) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        c    <= res;
        d    <= {res[WIDTH-1], res == '0, ovf};
        busy <= 1'b0;
      end
    end
  end

endmodule
